// File: rtl/jbus_xfer.sv
// Bus-transfer sequencer for the 8-bit JCS bus: runs one four-quarter bus cycle
// (setup, enable, enable+set, hold) moving a word from register SRC to register DST.
module jbus_xfer #(
    parameter int QLEN  = 2,
    parameter int FIRST = 1,
    parameter int LAST  = 7
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [3:0]  SRC,
    input  logic [3:0]  DST,
    output logic [15:0] ENA,
    output logic [15:0] SET,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  PHASE
);

    typedef enum logic [2:0] {IDLE, SETUP, EN, ENSET, HOLD} state_t;

    localparam logic [7:0] QMAX = 8'(QLEN - 1);
    localparam logic [3:0] LO   = 4'(FIRST);
    localparam logic [3:0] HI   = 4'(LAST);

    state_t     state;
    logic [7:0] qcnt;
    logic [3:0] src_q;
    logic [3:0] dst_q;
    logic       legal;

    assign legal = (SRC >= LO) && (SRC <= HI) &&
                   (DST >= LO) && (DST <= HI) &&
                   (SRC != DST);

    // Outputs are updated on the same edge as the state change, so they are
    // already correct for the quarter being entered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            qcnt  <= '0;
            src_q <= '0;
            dst_q <= '0;
            ENA   <= '0;
            SET   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
            PHASE <= 2'd0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            if (state == IDLE) begin
                qcnt <= '0;
                if (START) begin
                    if (legal) begin
                        src_q <= SRC;
                        dst_q <= DST;
                        state <= SETUP;
                        BUSY  <= 1'b1;
                        PHASE <= 2'd0;
                    end else begin
                        ERR <= 1'b1;
                    end
                end
            end else if (qcnt != QMAX) begin
                qcnt <= qcnt + 8'd1;
            end else begin
                qcnt <= '0;
                case (state)
                    SETUP: begin
                        state <= EN;
                        ENA   <= 16'b1 << src_q;
                        PHASE <= 2'd1;
                    end
                    EN: begin
                        state <= ENSET;
                        SET   <= 16'b1 << dst_q;
                        PHASE <= 2'd2;
                    end
                    ENSET: begin
                        state <= HOLD;
                        SET   <= '0;
                        PHASE <= 2'd3;
                    end
                    default: begin
                        // End of HOLD: drop the bus and report completion together.
                        state <= IDLE;
                        ENA   <= '0;
                        SET   <= '0;
                        PHASE <= 2'd0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jbus_xfer.sv
// Self-checking bench for jbus_xfer: three instances (QLEN 1,2,3) share one stimulus
// stream and are each compared every cycle against a time-based reference model.
module tb_jbus_xfer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [3:0]  SRC;
    logic [3:0]  DST;
    logic [15:0] ena   [3];
    logic [15:0] set_o [3];
    logic        busy  [3];
    logic        done  [3];
    logic        err   [3];
    logic [1:0]  phase [3];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        jbus_xfer #(.QLEN(g + 1), .FIRST(1), .LAST(7)) u_dut (
            .CLK   (CLK),
            .RESET (RESET),
            .START (START),
            .SRC   (SRC),
            .DST   (DST),
            .ENA   (ena[g]),
            .SET   (set_o[g]),
            .BUSY  (busy[g]),
            .DONE  (done[g]),
            .ERR   (err[g]),
            .PHASE (phase[g])
        );
    end

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic check_val(input string name, input int idx,
                             input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (QLEN=%0d): got %h, expected %h", name, idx + 1, act, exp);
        end
    endtask

    // Reference model: a transfer is just "cycles elapsed since acceptance";
    // the quarter is elapsed/QLEN, and outputs follow from the quarter number.
    int m_t    [3];
    int m_src  [3];
    int m_dst  [3];
    bit m_busy [3];
    bit m_done [3];
    bit m_err  [3];

    function automatic bit legal(input int s, input int d);
        return (s >= 1) && (s <= 7) && (d >= 1) && (d <= 7) && (s != d);
    endfunction

    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            m_done[i] = 1'b0;
            m_err[i]  = 1'b0;
            if (RESET) begin
                m_busy[i] = 1'b0;
                m_t[i]    = 0;
            end else if (m_busy[i]) begin
                m_t[i]++;
                if (m_t[i] == 4 * (i + 1)) begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                end
            end else if (START) begin
                if (legal(int'(SRC), int'(DST))) begin
                    m_busy[i] = 1'b1;
                    m_t[i]    = 0;
                    m_src[i]  = int'(SRC);
                    m_dst[i]  = int'(DST);
                end else begin
                    m_err[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                int quarter;
                quarter = m_busy[i] ? m_t[i] / (i + 1) : 0;
                check_val("model_busy",  i, 16'(busy[i]),  16'(m_busy[i]));
                check_val("model_done",  i, 16'(done[i]),  16'(m_done[i]));
                check_val("model_err",   i, 16'(err[i]),   16'(m_err[i]));
                check_val("model_phase", i, 16'(phase[i]), 16'(quarter));
                check_val("model_ena",   i, ena[i],
                          (m_busy[i] && quarter >= 1) ? (16'b1 << m_src[i]) : 16'h0000);
                check_val("model_set",   i, set_o[i],
                          (m_busy[i] && quarter == 2) ? (16'b1 << m_dst[i]) : 16'h0000);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy[0] || busy[1] || busy[2]) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("[TB] FAIL wait_idle: still busy after %0d cycles, required idle", n);
        end
    endtask

    typedef struct {
        logic [3:0] src;
        logic [3:0] dst;
        logic       exp_busy;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [1:0]  ph_b [9];
        logic [1:0]  ph_o [7];
        logic        bz_o [7];
        logic        dn_o [7];
        logic [15:0] en_o [7];
        logic [15:0] st_o [7];
        int          nbusy;
        int          ndone;

        vecs[0] = '{4'd0,  4'd3,  1'b0, 1'b1};
        vecs[1] = '{4'd4,  4'd4,  1'b0, 1'b1};
        vecs[2] = '{4'd8,  4'd2,  1'b0, 1'b1};
        vecs[3] = '{4'd1,  4'd7,  1'b1, 1'b0};
        vecs[4] = '{4'd7,  4'd1,  1'b1, 1'b0};
        vecs[5] = '{4'd2,  4'd15, 1'b0, 1'b1};
        vecs[6] = '{4'd15, 4'd15, 1'b0, 1'b1};
        vecs[7] = '{4'd3,  4'd0,  1'b0, 1'b1};

        ph_b = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        ph_o = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
        bz_o = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        dn_o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        en_o = '{16'h0000, 16'h0080, 16'h0080, 16'h0080, 16'h0000, 16'h0000, 16'h0008};
        st_o = '{16'h0000, 16'h0000, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

        RESET = 1'b1;
        START = 1'b0;
        SRC   = 4'd0;
        DST   = 4'd0;
        repeat (2) @(negedge CLK);
        RESET  = 1'b0;
        chk_on = 1'b1;

        // Reset then idle
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check_val("idle_ena",   1, ena[1],   16'h0000);
            check_val("idle_set",   1, set_o[1], 16'h0000);
            check_val("idle_busy",  1, 16'(busy[1]),  16'h0000);
            check_val("idle_done",  1, 16'(done[1]),  16'h0000);
            check_val("idle_err",   1, 16'(err[1]),   16'h0000);
            check_val("idle_phase", 1, 16'(phase[1]), 16'h0000);
        end

        // Basic transfer, QLEN=2, SRC=1 DST=2
        START = 1'b1; SRC = 4'd1; DST = 4'd2;
        for (int c = 1; c <= 9; c++) begin
            @(negedge CLK);
            check_val("basic_busy",  1, 16'(busy[1]),  16'((c <= 8) ? 1 : 0));
            check_val("basic_phase", 1, 16'(phase[1]), 16'(ph_b[c-1]));
            check_val("basic_ena",   1, ena[1],   (c >= 3 && c <= 8) ? 16'h0002 : 16'h0000);
            check_val("basic_set",   1, set_o[1], (c == 5 || c == 6) ? 16'h0004 : 16'h0000);
            check_val("basic_done",  1, 16'(done[1]),  16'((c == 9) ? 1 : 0));
            if (c == 1) START = 1'b0;
        end
        wait_idle();

        // Accept/reject table on the QLEN=2 instance
        for (int v = 0; v < 8; v++) begin
            START = 1'b1; SRC = vecs[v].src; DST = vecs[v].dst;
            @(negedge CLK);
            START = 1'b0;
            check_val("tab_busy", 1, 16'(busy[1]), 16'(vecs[v].exp_busy));
            check_val("tab_err",  1, 16'(err[1]),  16'(vecs[v].exp_err));
            check_val("tab_ena",  1, ena[1], 16'h0000);
            @(negedge CLK);
            check_val("tab_err_pulse", 1, 16'(err[1]), 16'h0000);
            wait_idle();
        end

        // Busy overlap plus back-to-back, QLEN=1
        START = 1'b1; SRC = 4'd7; DST = 4'd3;
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            check_val("b2b_busy",  0, 16'(busy[0]),  16'(bz_o[c-1]));
            check_val("b2b_phase", 0, 16'(phase[0]), 16'(ph_o[c-1]));
            check_val("b2b_ena",   0, ena[0],   en_o[c-1]);
            check_val("b2b_set",   0, set_o[0], st_o[c-1]);
            check_val("b2b_done",  0, 16'(done[0]), 16'(dn_o[c-1]));
            check_val("b2b_err",   0, 16'(err[0]),  16'h0000);
            START = 1'b0;
            if (c == 2) begin START = 1'b1; SRC = 4'd1; DST = 4'd2; end
            if (c == 5) begin START = 1'b1; SRC = 4'd3; DST = 4'd5; end
        end
        wait_idle();

        // Reset mid-operation, QLEN=3
        START = 1'b1; SRC = 4'd2; DST = 4'd6;
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        check_val("rst_pre_phase", 2, 16'(phase[2]), 16'd2);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check_val("rst_ena",  2, ena[2],   16'h0000);
        check_val("rst_set",  2, set_o[2], 16'h0000);
        check_val("rst_busy", 2, 16'(busy[2]), 16'h0000);
        check_val("rst_done", 2, 16'(done[2]), 16'h0000);
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            check_val("rst_no_done", 2, 16'(done[2]), 16'h0000);
        end
        START = 1'b1; SRC = 4'd2; DST = 4'd6;
        nbusy = 0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (busy[2]) nbusy++;
            if (done[2]) ndone++;
        end
        check_val("rst_fresh_busy_cycles", 2, 16'(nbusy), 16'd12);
        check_val("rst_fresh_done_count",  2, 16'(ndone), 16'd1);

        // Random stimulus against the model
        for (int c = 0; c < 600; c++) begin
            RESET = ($urandom_range(0, 99) == 0);
            START = ($urandom_range(0, 2) == 0);
            SRC   = 4'($urandom_range(0, 9));
            DST   = 4'($urandom_range(0, 9));
            @(negedge CLK);
        end
        RESET = 1'b0;
        START = 1'b0;
        wait_idle();
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
